// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential IEEE-754 single-precision divider p = a / b
//
// Restoring mantissa division: one quotient bit per cycle over ITER cycles,
// then a single normalise/pack cycle. Implicit leading 1 on nonzero operands,
// truncation without rounding, no denormal/NaN/inf operand decoding.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset; aborts any operation in flight
//   start_i  request, sampled only in IDLE
//   a_i      dividend (IEEE-754 single), sampled with start_i
//   b_i      divisor (IEEE-754 single), sampled with start_i
//   busy_o   high while CALC or NORM
//   done_o   one-cycle pulse when p_o and flags are valid
//   p_o      quotient, held until the next done_o
//   dz_o     divide by zero, held with p_o
//   ovf_o    exponent overflow, held with p_o
//   unf_o    exponent underflow, held with p_o
module fp_div_seq #(
  parameter int ITER = 25
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] p_o,
  output logic        dz_o,
  output logic        ovf_o,
  output logic        unf_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_NORM = 2'd2
  } state_t;

  state_t             state_q;
  logic        [4:0]  cnt_q;
  logic               sign_q;
  logic        [23:0] mb_q;
  logic signed [9:0]  e_q;
  logic        [25:0] r_q;
  logic        [24:0] q_q;

  logic        [31:0] p_q;
  logic               busy_q, done_q, dz_q, ovf_q, unf_q;

  // Special-case results are staged one cycle so they appear on the edge
  // after the start edge, while the FSM itself never leaves IDLE.
  logic               spec_pend_q;
  logic        [31:0] spec_p_q;
  logic               spec_dz_q;

  logic               r_ge_d;
  logic        [25:0] r_diff_d;
  logic        [25:0] r_d;
  logic        [24:0] q_d;
  logic        [22:0] mant_d;
  logic signed [9:0]  ef_d;
  logic        [9:0]  e_start_d;
  logic               sign_start_d;

  always_comb begin
    r_ge_d       = (r_q >= {2'b00, mb_q});
    r_diff_d     = r_q - {2'b00, mb_q};
    r_d          = r_ge_d ? (r_diff_d << 1) : (r_q << 1);
    q_d          = {q_q[23:0], r_ge_d};
    // Q[24] is the integer bit; when clear the quotient is in [0.5,1)
    // and one extra fraction bit moves up with the exponent decremented.
    mant_d       = q_q[24] ? q_q[23:1] : q_q[22:0];
    ef_d         = q_q[24] ? e_q : (e_q - 10'sd1);
    e_start_d    = {2'b00, a_i[30:23]} - {2'b00, b_i[30:23]} + 10'd127;
    sign_start_d = a_i[31] ^ b_i[31];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      mb_q        <= '0;
      e_q         <= '0;
      r_q         <= '0;
      q_q         <= '0;
      p_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      spec_pend_q <= 1'b0;
      spec_p_q    <= '0;
      spec_dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (spec_pend_q) begin
        p_q         <= spec_p_q;
        dz_q        <= spec_dz_q;
        ovf_q       <= 1'b0;
        unf_q       <= 1'b0;
        done_q      <= 1'b1;
        spec_pend_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (b_i[30:0] == 31'd0) begin
              spec_pend_q <= 1'b1;
              spec_dz_q   <= 1'b1;
              spec_p_q    <= (a_i[30:0] == 31'd0) ? 32'h7FC0_0000
                                                  : {sign_start_d, 8'hFF, 23'd0};
            end else if (a_i[30:0] == 31'd0) begin
              spec_pend_q <= 1'b1;
              spec_dz_q   <= 1'b0;
              spec_p_q    <= 32'h0000_0000;
            end else begin
              sign_q  <= sign_start_d;
              mb_q    <= {1'b1, b_i[22:0]};
              e_q     <= $signed(e_start_d);
              r_q     <= {2'b00, 1'b1, a_i[22:0]};
              q_q     <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end
        end

        S_CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1)) begin
            state_q <= S_NORM;
          end
        end

        S_NORM: begin
          if (ef_d >= 10'sd255) begin
            p_q   <= {sign_q, 8'hFF, 23'd0};
            dz_q  <= 1'b0;
            ovf_q <= 1'b1;
            unf_q <= 1'b0;
          end else if (ef_d <= 10'sd0) begin
            p_q   <= {sign_q, 31'd0};
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b1;
          end else begin
            p_q   <= {sign_q, ef_d[7:0], mant_d};
            dz_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign p_o    = p_q;
  assign dz_o   = dz_q;
  assign ovf_o  = ovf_q;
  assign unf_o  = unf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - scoreboard testbench for fp_div_seq
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] p;
  logic        dz;
  logic        ovf;
  logic        unf;

  fp_div_seq #(.ITER(25)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .p_o     (p),
    .dz_o    (dz),
    .ovf_o   (ovf),
    .unf_o   (unf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] p;
    logic [2:0]  flags;
    int          due;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_p"}, p, e.p);
        chk({e.name, "_flags"}, {29'd0, dz, ovf, unf}, {29'd0, e.flags});
        chk({e.name, "_latency"}, cyc, e.due);
      end
    end
  end

  task automatic drive(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Start is sampled at the next rising edge k (= cyc + 1); done is
  // expected visible at the negedge where cyc == k + lat.
  task automatic issue(input string nm, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ep, input logic [2:0] ef, input int lat);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    sbq.push_back('{p: ep, flags: ef, due: cyc + 1 + lat, name: nm});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
    end
  endtask

  initial begin
    int busy_low;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_p", p, 32'd0);
    chk("reset_flags", {29'd0, dz, ovf, unf}, 32'd0);
    rst = 1'b0;

    // 6 / 2 = 3, busy held through CALC and NORM
    issue("div6_2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 26);
    busy_low = 0;
    for (int i = 0; i < 26; i++) begin
      if (busy !== 1'b1) busy_low++;
      if (i < 25) @(negedge clk);
    end
    chk("busy_during_op", busy_low, 0);
    wait_done("div6_2");
    chk("busy_after_done", {31'd0, busy}, 32'd0);

    issue("neg7p5_2p5", 32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 3'b000, 26);
    wait_done("neg7p5_2p5");

    issue("one_third", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000, 26);
    wait_done("one_third");

    issue("div_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 3'b100, 1);
    wait_done("div_by_zero");

    issue("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b100, 1);
    wait_done("zero_by_zero");

    issue("zero_dividend", 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 3'b000, 1);
    wait_done("zero_dividend");

    issue("overflow", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 3'b010, 26);
    wait_done("overflow");

    issue("underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 3'b001, 26);
    wait_done("underflow");

    // start pulsed five cycles into an operation must be ignored
    issue("ignore_start", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 26);
    repeat (3) @(negedge clk);
    drive(32'h3F80_0000, 32'h4040_0000);
    wait_done("ignore_start");

    // back-to-back: second start issued during the done cycle
    issue("b2b_first", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 3'b000, 26);
    wait_done("b2b_first");
    a     = 32'hC0F0_0000;
    b     = 32'h4020_0000;
    start = 1'b1;
    sbq.push_back('{p: 32'hC040_0000, flags: 3'b000, due: cyc + 1 + 26, name: "b2b_second"});
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_second");

    // reset mid-CALC aborts without a later done
    drive(32'h40C0_0000, 32'h4000_0000);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_p", p, 32'd0);
    chk("midreset_flags", {29'd0, dz, ovf, unf}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue("after_reset", 32'hC0F0_0000, 32'h4020_0000, 32'hC040_0000, 3'b000, 26);
    wait_done("after_reset");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
Name: fp_div_seq

Overview:
- Sequential IEEE-754 single-precision divider, p = a / b. It is the inverse operation to the team's combinational fp multiplier.
- Uses a restoring mantissa division: one quotient bit per cycle, 25 iterations, then one normalise/pack cycle.
- Uses the same number conventions as the multiplier: implicit leading 1 on every nonzero operand, truncation with no rounding, and no denormal, NaN or inf operand decoding.
- Sits on the arithmetic datapath behind a start/done handshake.

Parameters:
ITER, 25, number of quotient bits generated (1 integer bit + 24 fraction bits); fixed for single precision.

Ports:
clk    input   1   clock; all state updates on the rising edge
rst    input   1   synchronous, active-high reset
start  input   1   request; sampled only in IDLE
a      input   32  dividend, IEEE-754 single; sampled with start
b      input   32  divisor, IEEE-754 single; sampled with start
busy   output  1   high while in CALC or NORM
done   output  1   one-cycle pulse when p and the flags are valid
p      output  32  quotient; holds until the next done
dz     output  1   divide by zero; valid with done, held with p
ovf    output  1   exponent overflow; valid with done, held with p
unf    output  1   exponent underflow; valid with done, held with p

Behaviour:
- Reset, synchronous and active-high:
  - State = IDLE; p = 0, done = 0, busy = 0, dz = ovf = unf = 0; iteration counter = 0.
  - Reset mid-operation aborts the operation. No done is produced.
- States and transitions:
  - IDLE → CALC on start.
  - CALC → NORM after 25 iterations.
  - NORM → IDLE.
  - Special-case starts go IDLE → IDLE.
- Latching on start in IDLE:
  - Latch sign s = a[31]^b[31].
  - Latch ma = {1,a[22:0]} and mb = {1,b[22:0]}.
  - Latch e = a[30:23] - b[30:23] + 127, as a 10-bit signed value.
  - Set remainder R = ma (26-bit) and clear quotient Q (25-bit).
- Special cases, resolved at the start edge: p, flags and done are valid one cycle later and the state stays IDLE.
  - b[30:0]==0 and a[30:0]==0: p = 0x7FC00000, dz = 1.
  - b[30:0]==0 only: p = {s,8'hFF,23'b0}, dz = 1.
  - a[30:0]==0: p = 0x00000000, all flags 0.
- CALC, each cycle:
  - If R >= mb: Q = {Q[23:0],1} and R = (R-mb)<<1.
  - Otherwise: Q = {Q[23:0],0} and R = R<<1.
  - After 25 cycles Q = floor(ma·2^24/mb), with Q[24] = integer bit.
  - R stays below 2^26.
- NORM:
  - If Q[24]=1: mantissa = Q[23:1], ef = e.
  - If Q[24]=0: mantissa = Q[22:0], ef = e-1.
  - If ef >= 255: p = {s,8'hFF,23'b0}, ovf = 1.
  - If ef <= 0: p = {s,31'b0}, unf = 1.
  - Otherwise: p = {s,ef[7:0],mantissa}.
  - done is asserted on the NORM edge.
- Latency: if start is sampled at edge k, done is high in the cycle after edge k+26. Special cases: done is high in the cycle after edge k+1.
- busy: high from edge k to edge k+26; low in IDLE.
- start while busy is ignored. No queuing and no corruption of the operation in flight.
- Back-to-back: start is accepted in the cycle where done is high, because the state is already IDLE.
- dz, ovf and unf are mutually exclusive. They are updated only together with p.

Test Plan:
- Reset: hold rst for 2 cycles mid-CALC → busy = 0 and done = 0 with no later pulse; p = 0 and all flags 0.
- Exact quotient: a = 0x40C00000, b = 0x40000000 → p = 0x40400000, done 26 cycles after start, busy high throughout. Then a = 0xC0F00000, b = 0x40200000 → p = 0xC0400000.
- Truncation: a = 0x3F800000, b = 0x40400000 → p = 0x3EAAAAAA (Q[24] = 0 normalise path).
- Special cases:
  - a = 0x3F800000, b = 0 → p = 0x7F800000, dz = 1, latency 1.
  - a = 0, b = 0 → p = 0x7FC00000, dz = 1.
  - a = 0, b = 0x40000000 → p = 0, latency 1.
- Range:
  - a = 0x7F000000, b = 0x00800000 → p = 0x7F800000, ovf = 1.
  - a = 0x00800000, b = 0x7F000000 → p = 0x00000000, unf = 1.
- Handshake:
  - Pulse start at cycle 5 of an operation → ignored, original result unchanged.
  - Assert start in the done cycle → second result follows 26 cycles later, correct.
